wptr_full_pkt: RTL and testbench

Write-side pointer and flag generator for the next-generation FIFO. It computes the write address, the full and almost-full flags and the fill level, and publishes a Gray-coded write pointer for the read side. It adds a packet mode in which writes stay private until a frame is committed, so the Ethernet RX path can drop bad frames by rewinding. Sits in the write domain, between the MAC RX writer and the FIFO RAM and pointer synchronizer.

---
 rtl/wptr_full_pkt.sv | 108 ++++++++++
 tb/tb_wptr_full_pkt.sv | 134 +++++++++++++
 2 files changed

// File: rtl/wptr_full_pkt.sv
// rtl/wptr_full_pkt.sv - FIFO write-side pointer/flag generator with optional commit/discard packet framing
module wptr_full_pkt #(
  parameter int ADDRSIZE = 4,
  parameter bit PKT_MODE = 1'b1
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic                wcommit,
  input  logic                wdiscard,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wdrop
);

  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    for (int i = 0; i <= ADDRSIZE; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] cbin_q, cbin_d;
  logic              bad_q, bad_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic              wfull_q, wfull_d;
  logic              awfull_q, awfull_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wdrop_q, wdrop_d;

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] wbinnext;
  logic              wen;
  logic              frame_bad;

  always_comb begin
    rbin      = gray2bin(wq2_rptr);
    wen       = winc & ~wfull_q & ~bad_q & ~(PKT_MODE & wdiscard);
    wbinnext  = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    // A frame that lost any word to overflow can never be committed.
    frame_bad = bad_q | (winc & wfull_q);

    wbin_d  = wbinnext;
    cbin_d  = cbin_q;
    bad_d   = 1'b0;
    wptr_d  = wptr_q;
    wdrop_d = 1'b0;

    if (!PKT_MODE) begin
      cbin_d  = wbinnext;
      wptr_d  = bin2gray(wbinnext);
      wdrop_d = winc & wfull_q;
    end else if (wdiscard || (wcommit && frame_bad)) begin
      wbin_d  = cbin_q;
      wdrop_d = ~wdiscard;
    end else if (wcommit) begin
      cbin_d = wbinnext;
      wptr_d = bin2gray(wbinnext);
    end else begin
      bad_d = frame_bad;
    end

    wlevel_d = wbin_d - rbin;
    wfull_d  = (wlevel_d == DEPTH);
    awfull_d = (afull_thresh != '0) && (wlevel_d >= afull_thresh);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      cbin_q   <= '0;
      bad_q    <= 1'b0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wlevel_q <= '0;
      wdrop_q  <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      cbin_q   <= cbin_d;
      bad_q    <= bad_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      wlevel_q <= wlevel_d;
      wdrop_q  <= wdrop_d;
    end
  end

  assign waddr  = wbin_q[ADDRSIZE-1:0];
  assign wptr   = wptr_q;
  assign wfull  = wfull_q;
  assign awfull = awfull_q;
  assign wlevel = wlevel_q;
  assign wdrop  = wdrop_q;

endmodule

// File: tb/tb_wptr_full_pkt.sv
// tb/tb_wptr_full_pkt.sv - scoreboard bench for wptr_full_pkt in streaming and packet modes
module tb_wptr_full_pkt;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic       wcommit = 1'b0;
  logic       wdiscard = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic [4:0] afull_thresh = '0;

  logic [3:0] waddr0, waddr1;
  logic [4:0] wptr0, wptr1, wlevel0, wlevel1;
  logic       wfull0, wfull1, awfull0, awfull1, wdrop0, wdrop1;

  always #5 wclk = ~wclk;

  wptr_full_pkt #(.ADDRSIZE(4), .PKT_MODE(1'b0)) u_dut0 (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wcommit(wcommit), .wdiscard(wdiscard),
    .wq2_rptr(wq2_rptr), .afull_thresh(afull_thresh), .waddr(waddr0), .wptr(wptr0),
    .wfull(wfull0), .awfull(awfull0), .wlevel(wlevel0), .wdrop(wdrop0)
  );

  wptr_full_pkt #(.ADDRSIZE(4), .PKT_MODE(1'b1)) u_dut1 (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wcommit(wcommit), .wdiscard(wdiscard),
    .wq2_rptr(wq2_rptr), .afull_thresh(afull_thresh), .waddr(waddr1), .wptr(wptr1),
    .wfull(wfull1), .awfull(awfull1), .wlevel(wlevel1), .wdrop(wdrop1)
  );

  typedef struct {
    logic        sel;
    logic [16:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Vector layout: {waddr, wptr, wfull, awfull, wlevel, wdrop}
  always @(negedge wclk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [16:0] act;
      e   = sb.pop_front();
      act = e.sel ? {waddr1, wptr1, wfull1, awfull1, wlevel1, wdrop1}
                  : {waddr0, wptr0, wfull0, awfull0, wlevel0, wdrop0};
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got waddr=%0d wptr=%b wfull=%b awfull=%b wlevel=%0d wdrop=%b, want waddr=%0d wptr=%b wfull=%b awfull=%b wlevel=%0d wdrop=%b",
                 e.nm, act[16:13], act[12:8], act[7], act[6], act[5:1], act[0],
                 e.exp[16:13], e.exp[12:8], e.exp[7], e.exp[6], e.exp[5:1], e.exp[0]);
      end
    end
  end

  task automatic cyc(input string nm, input logic s, input logic i_inc, input logic i_com,
                     input logic i_dis, input logic i_rst, input logic [3:0] e_addr,
                     input logic [4:0] e_ptr, input logic e_full, input logic e_af,
                     input logic [4:0] e_lvl, input logic e_drop);
    exp_t e;
    winc     = i_inc;
    wcommit  = i_com;
    wdiscard = i_dis;
    wrst     = i_rst;
    @(posedge wclk);
    #1;
    e.sel = s;
    e.exp = {e_addr, e_ptr, e_full, e_af, e_lvl, e_drop};
    e.nm  = nm;
    sb.push_back(e);
  endtask

  initial begin
    // Streaming mode: fill to full, then one rejected write, then reset with a write pending.
    cyc("m0_reset", 0, 0, 0, 0, 1, 4'd0, 5'd0, 0, 0, 5'd0, 0);
    for (int i = 1; i <= 16; i++)
      cyc("m0_fill", 0, 1, 0, 0, 0, 4'(i), gray5(5'(i)), i == 16, 0, 5'(i), 0);
    cyc("m0_overflow", 0, 1, 0, 0, 0, 4'd0, 5'b11000, 1, 0, 5'd16, 1);
    cyc("m0_drop_end", 0, 0, 0, 0, 0, 4'd0, 5'b11000, 1, 0, 5'd16, 0);
    cyc("m0_reset_winc", 0, 1, 0, 0, 1, 4'd0, 5'd0, 0, 0, 5'd0, 0);

    // Packet mode: commit, discard, refill and commit at 10.
    cyc("m1_reset", 1, 0, 0, 0, 1, 4'd0, 5'd0, 0, 0, 5'd0, 0);
    for (int i = 1; i <= 5; i++)
      cyc("m1_commit", 1, 1, i == 5, 0, 0, 4'(i), (i == 5) ? 5'b00111 : 5'd0, 0, 0, 5'(i), 0);
    for (int i = 1; i <= 3; i++)
      cyc("m1_frame", 1, 1, 0, 0, 0, 4'(5 + i), 5'b00111, 0, 0, 5'(5 + i), 0);
    cyc("m1_discard", 1, 0, 0, 1, 0, 4'd5, 5'b00111, 0, 0, 5'd5, 0);
    for (int i = 1; i <= 5; i++)
      cyc("m1_refill", 1, 1, i == 5, 0, 0, 4'(5 + i), (i == 5) ? 5'b01111 : 5'b00111, 0, 0, 5'(5 + i), 0);

    // Overflowing frame: six words fit, the rest mark the frame bad, commit becomes a drop.
    for (int i = 1; i <= 8; i++) begin
      int acc;
      acc = (i <= 6) ? i : 6;
      cyc("m1_ovf_write", 1, 1, 0, 0, 0, 4'(10 + acc), 5'b01111, acc == 6, 0, 5'(10 + acc), 0);
    end
    cyc("m1_ovf_commit", 1, 0, 1, 0, 0, 4'd10, 5'b01111, 0, 0, 5'd10, 1);
    cyc("m1_ovf_idle", 1, 0, 0, 0, 0, 4'd10, 5'b01111, 0, 0, 5'd10, 0);

    // Almost-full threshold, release by read pointer, then disabled threshold.
    afull_thresh = 5'd12;
    cyc("m1_af_11", 1, 1, 0, 0, 0, 4'd11, 5'b01111, 0, 0, 5'd11, 0);
    cyc("m1_af_12", 1, 1, 0, 0, 0, 4'd12, 5'b01111, 0, 1, 5'd12, 0);
    wq2_rptr = 5'b00110;
    cyc("m1_af_read", 1, 0, 0, 0, 0, 4'd12, 5'b01111, 0, 0, 5'd8, 0);
    afull_thresh = 5'd0;
    for (int i = 1; i <= 8; i++)
      cyc("m1_af_off", 1, 1, 0, 0, 0, 4'(12 + i), 5'b01111, i == 8, 0, 5'(8 + i), 0);

    // Simultaneous commit+discard (+write) discards; then reset with write pending.
    cyc("m1_com_dis", 1, 1, 1, 1, 0, 4'd10, 5'b01111, 0, 0, 5'd6, 0);
    cyc("m1_reset_winc", 1, 1, 0, 0, 1, 4'd0, 5'd0, 0, 0, 5'd0, 0);

    winc = 1'b0;
    wcommit = 1'b0;
    wdiscard = 1'b0;
    repeat (3) @(negedge wclk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
